// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel-enable divider, H/V counters, blank/sync/DE flags
// and line/frame strobes, with an optional line-doubled vertical mode.

module video_timing_gen_param_chk #(
    parameter int HW         = 10,
    parameter int VW         = 10,
    parameter int H_TOTAL    = 640,
    parameter int H_BL_START = 550,
    parameter int H_SY_START = 579,
    parameter int H_SY_END   = 611,
    parameter int V_TOTAL    = 312,
    parameter int V_BL_START = 300,
    parameter int V_SY_START = 304,
    parameter int V_SY_END   = 308
) ();
    generate
        if (!((H_BL_START < H_SY_START) && (H_SY_START < H_SY_END) && (H_SY_END <= H_TOTAL))) begin : g_h_bad
            $error("video_timing_gen: illegal horizontal timing parameters");
        end
        if (!((V_BL_START < V_SY_START) && (V_SY_START < V_SY_END) && (V_SY_END <= V_TOTAL))) begin : g_v_bad
            $error("video_timing_gen: illegal vertical timing parameters");
        end
        if ((V_TOTAL + V_TOTAL) > (32'd1 << VW)) begin : g_vw_bad
            $error("video_timing_gen: VW too narrow for doubled frame");
        end
        if (H_TOTAL > (32'd1 << HW)) begin : g_hw_bad
            $error("video_timing_gen: HW too narrow for line length");
        end
    endgenerate
endmodule

module video_timing_gen #(
    parameter int HW         = 10,
    parameter int VW         = 10,
    parameter int H_TOTAL    = 640,
    parameter int H_BL_START = 550,
    parameter int H_SY_START = 579,
    parameter int H_SY_END   = 611,
    parameter int V_TOTAL    = 312,
    parameter int V_BL_START = 300,
    parameter int V_SY_START = 304,
    parameter int V_SY_END   = 308,
    parameter int HS_POL     = 1,
    parameter int VS_POL     = 1
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          line_double,
    input  logic [1:0]    ce_div,
    output logic          ce_pix,
    output logic [HW-1:0] hc,
    output logic [VW-1:0] vc,
    output logic [VW-1:0] vline,
    output logic          hblank,
    output logic          vblank,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          new_line,
    output logic          new_frame,
    output logic [15:0]   frame_cnt
);

    // Thresholds carry one spare bit so a sync end equal to the total never truncates.
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 32'd1);
    localparam logic [HW-1:0] H_ONE    = HW'(32'd1);
    localparam logic [HW:0]   H_BL     = (HW+1)'(H_BL_START);
    localparam logic [HW:0]   H_SS     = (HW+1)'(H_SY_START);
    localparam logic [HW:0]   H_SE     = (HW+1)'(H_SY_END);
    localparam logic [VW-1:0] V_ONE    = VW'(32'd1);
    localparam logic [VW-1:0] VT1_LAST = VW'(V_TOTAL - 32'd1);
    localparam logic [VW-1:0] VT2_LAST = VW'(V_TOTAL + V_TOTAL - 32'd1);
    localparam logic [VW:0]   V_BL1    = (VW+1)'(V_BL_START);
    localparam logic [VW:0]   V_SS1    = (VW+1)'(V_SY_START);
    localparam logic [VW:0]   V_SE1    = (VW+1)'(V_SY_END);
    localparam logic [VW:0]   V_BL2    = (VW+1)'(V_BL_START + V_BL_START);
    localparam logic [VW:0]   V_SS2    = (VW+1)'(V_SY_START + V_SY_START);
    localparam logic [VW:0]   V_SE2    = (VW+1)'(V_SY_END + V_SY_END);
    localparam logic          HS_ACT   = (HS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic          VS_ACT   = (VS_POL != 0) ? 1'b1 : 1'b0;

    video_timing_gen_param_chk #(
        .HW(HW), .VW(VW),
        .H_TOTAL(H_TOTAL), .H_BL_START(H_BL_START), .H_SY_START(H_SY_START), .H_SY_END(H_SY_END),
        .V_TOTAL(V_TOTAL), .V_BL_START(V_BL_START), .V_SY_START(V_SY_START), .V_SY_END(V_SY_END)
    ) u_param_chk ();

    logic          init_done_r;
    logic [1:0]    div_q_r;
    logic          double_q_r;
    logic [1:0]    cnt_r;
    logic          ce_pix_r;
    logic [HW-1:0] hc_r;
    logic [VW-1:0] vc_r;
    logic [VW-1:0] vline_r;
    logic          hblank_r;
    logic          vblank_r;
    logic          hsync_r;
    logic          vsync_r;
    logic          de_r;
    logic          new_line_r;
    logic          new_frame_r;
    logic [15:0]   frame_cnt_r;

    logic          line_end_s;
    logic          frame_wrap_s;
    logic          sample_s;
    logic [VW-1:0] vt_last_s;
    logic [1:0]    div_use_s;
    logic          dbl_use_s;
    logic [1:0]    cnt_nxt_s;
    logic          ce_nxt_s;
    logic [HW-1:0] hc_nxt_s;
    logic [VW-1:0] vc_nxt_s;
    logic [VW-1:0] vline_nxt_s;
    logic [VW:0]   vbs_s;
    logic [VW:0]   vss_s;
    logic [VW:0]   vse_s;
    logic          hblank_nxt_s;
    logic          vblank_nxt_s;
    logic          hsync_nxt_s;
    logic          vsync_nxt_s;

    // Next-state: mode sampling, divider, counters and flags derived from the next position.
    always_comb begin
        line_end_s   = ce_pix_r && (hc_r == H_LAST);
        vt_last_s    = double_q_r ? VT2_LAST : VT1_LAST;
        frame_wrap_s = line_end_s && (vc_r == vt_last_s);
        sample_s     = !init_done_r || frame_wrap_s;
        div_use_s    = div_q_r;
        dbl_use_s    = double_q_r;
        cnt_nxt_s    = cnt_r;
        ce_nxt_s     = 1'b0;
        hc_nxt_s     = hc_r;
        vc_nxt_s     = vc_r;
        vbs_s        = V_BL1;
        vss_s        = V_SS1;
        vse_s        = V_SE1;
        hsync_nxt_s  = ~HS_ACT;
        vsync_nxt_s  = ~VS_ACT;

        // A new frame picks up the divider immediately so its first pixel already has the new width.
        if (sample_s) begin
            div_use_s = ce_div;
            dbl_use_s = line_double;
        end else begin
            div_use_s = div_q_r;
            dbl_use_s = double_q_r;
        end

        if (cnt_r >= div_use_s) begin
            cnt_nxt_s = 2'd0;
            ce_nxt_s  = 1'b1;
        end else begin
            cnt_nxt_s = cnt_r + 2'd1;
            ce_nxt_s  = 1'b0;
        end

        if (line_end_s) begin
            hc_nxt_s = {HW{1'b0}};
            if (frame_wrap_s) begin
                vc_nxt_s = {VW{1'b0}};
            end else begin
                vc_nxt_s = vc_r + V_ONE;
            end
        end else if (ce_pix_r) begin
            hc_nxt_s = hc_r + H_ONE;
            vc_nxt_s = vc_r;
        end else begin
            hc_nxt_s = hc_r;
            vc_nxt_s = vc_r;
        end

        if (dbl_use_s) begin
            vbs_s       = V_BL2;
            vss_s       = V_SS2;
            vse_s       = V_SE2;
            vline_nxt_s = {1'b0, vc_nxt_s[VW-1:1]};
        end else begin
            vbs_s       = V_BL1;
            vss_s       = V_SS1;
            vse_s       = V_SE1;
            vline_nxt_s = vc_nxt_s;
        end

        hblank_nxt_s = ({1'b0, hc_nxt_s} >= H_BL);
        vblank_nxt_s = ({1'b0, vc_nxt_s} >= vbs_s);

        if (({1'b0, hc_nxt_s} >= H_SS) && ({1'b0, hc_nxt_s} < H_SE)) begin
            hsync_nxt_s = HS_ACT;
        end else begin
            hsync_nxt_s = ~HS_ACT;
        end

        if (({1'b0, vc_nxt_s} >= vss_s) && ({1'b0, vc_nxt_s} < vse_s)) begin
            vsync_nxt_s = VS_ACT;
        end else begin
            vsync_nxt_s = ~VS_ACT;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            init_done_r <= 1'b0;
            div_q_r     <= 2'd0;
            double_q_r  <= 1'b0;
            cnt_r       <= 2'd0;
            ce_pix_r    <= 1'b0;
            hc_r        <= {HW{1'b0}};
            vc_r        <= {VW{1'b0}};
            vline_r     <= {VW{1'b0}};
            hblank_r    <= 1'b0;
            vblank_r    <= 1'b0;
            hsync_r     <= ~HS_ACT;
            vsync_r     <= ~VS_ACT;
            de_r        <= 1'b0;
            new_line_r  <= 1'b0;
            new_frame_r <= 1'b0;
            frame_cnt_r <= 16'd0;
        end else begin
            init_done_r <= 1'b1;
            div_q_r     <= div_use_s;
            double_q_r  <= dbl_use_s;
            cnt_r       <= cnt_nxt_s;
            ce_pix_r    <= ce_nxt_s;
            hc_r        <= hc_nxt_s;
            vc_r        <= vc_nxt_s;
            vline_r     <= vline_nxt_s;
            hblank_r    <= hblank_nxt_s;
            vblank_r    <= vblank_nxt_s;
            hsync_r     <= hsync_nxt_s;
            vsync_r     <= vsync_nxt_s;
            de_r        <= ~(hblank_nxt_s | vblank_nxt_s);
            new_line_r  <= line_end_s;
            new_frame_r <= frame_wrap_s;
            if (frame_wrap_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    assign ce_pix    = ce_pix_r;
    assign hc        = hc_r;
    assign vc        = vc_r;
    assign vline     = vline_r;
    assign hblank    = hblank_r;
    assign vblank    = vblank_r;
    assign hsync     = hsync_r;
    assign vsync     = vsync_r;
    assign de        = de_r;
    assign new_line  = new_line_r;
    assign new_frame = new_frame_r;
    assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a reduced raster checked every clock against an
// arithmetic model (pixel index from elapsed clocks), plus mode and reset sequences.

module tb_video_timing_gen;

    localparam int HW  = 6;
    localparam int VW  = 6;
    localparam int HT  = 20;
    localparam int HBS = 14;
    localparam int HSS = 16;
    localparam int HSE = 18;
    localparam int VT  = 10;
    localparam int VBS = 7;
    localparam int VSS = 8;
    localparam int VSE = 9;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          line_double;
    logic [1:0]    ce_div;

    logic          a_ce_pix, a_hblank, a_vblank, a_hsync, a_vsync, a_de, a_new_line, a_new_frame;
    logic [HW-1:0] a_hc;
    logic [VW-1:0] a_vc, a_vline;
    logic [15:0]   a_frame_cnt;
    logic          b_ce_pix, b_hblank, b_vblank, b_hsync, b_vsync, b_de, b_new_line, b_new_frame;
    logic [HW-1:0] b_hc;
    logic [VW-1:0] b_vc, b_vline;
    logic [15:0]   b_frame_cnt;

    video_timing_gen #(
        .HW(HW), .VW(VW), .H_TOTAL(HT), .H_BL_START(HBS), .H_SY_START(HSS), .H_SY_END(HSE),
        .V_TOTAL(VT), .V_BL_START(VBS), .V_SY_START(VSS), .V_SY_END(VSE), .HS_POL(1), .VS_POL(1)
    ) u_dut_a (
        .clk_sys(clk_sys), .reset_n(reset_n), .line_double(line_double), .ce_div(ce_div),
        .ce_pix(a_ce_pix), .hc(a_hc), .vc(a_vc), .vline(a_vline), .hblank(a_hblank),
        .vblank(a_vblank), .hsync(a_hsync), .vsync(a_vsync), .de(a_de),
        .new_line(a_new_line), .new_frame(a_new_frame), .frame_cnt(a_frame_cnt)
    );

    video_timing_gen #(
        .HW(HW), .VW(VW), .H_TOTAL(HT), .H_BL_START(HBS), .H_SY_START(HSS), .H_SY_END(HSE),
        .V_TOTAL(VT), .V_BL_START(VBS), .V_SY_START(VSS), .V_SY_END(VSE), .HS_POL(0), .VS_POL(0)
    ) u_dut_b (
        .clk_sys(clk_sys), .reset_n(reset_n), .line_double(line_double), .ce_div(ce_div),
        .ce_pix(b_ce_pix), .hc(b_hc), .vc(b_vc), .vline(b_vline), .hblank(b_hblank),
        .vblank(b_vblank), .hsync(b_hsync), .vsync(b_vsync), .de(b_de),
        .new_line(b_new_line), .new_frame(b_new_frame), .frame_cnt(b_frame_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    int vectors;
    int miscompares;
    // Model: clocks since reset release (e), start clock of current frame (s), frame mode.
    int e;
    int s;
    int md;
    int mdbl;
    int mframes;

    typedef struct {
        logic [1:0] div;
        logic       dbl;
        int         exp_period;
        int         exp_vmax;
        int         exp_vsync_lines;
    } mode_vec_t;

    mode_vec_t tbl[6];

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (clock %0d after reset)", nm, act, exp, e);
        end
    endtask

    task automatic check_reset();
        chk("rst_pos", int'({a_hc, a_vc, a_vline}), 0);
        chk("rst_flags", int'({a_ce_pix, a_hblank, a_vblank, a_de, a_new_line, a_new_frame}), 0);
        chk("rst_sync_pos_pol", int'({a_hsync, a_vsync}), 0);
        chk("rst_frame_cnt", int'(a_frame_cnt), 0);
        chk("rst_sync_neg_pol", int'({b_hsync, b_vsync}), 3);
        chk("rst_b_rest", int'({b_hc, b_vc, b_ce_pix, b_de, b_new_line, b_new_frame}), 0);
    endtask

    task automatic check_cycle();
        int n, vt, hc_e, vc_e, vl_e;
        bit ce_e, hb, vb, hs, vs, de_e, nl, nf, adv;
        e++;
        if (e == 1) begin
            s = 1; md = int'(ce_div); mdbl = int'(line_double); mframes = 0;
        end
        vt = VT << mdbl;
        n  = (e - s) / (md + 1);
        nf = 1'b0;
        if (n >= HT * vt) begin
            s = e; md = int'(ce_div); mdbl = int'(line_double);
            mframes = (mframes + 1) % 65536;
            n = 0; nf = 1'b1;
        end
        adv  = (e > s) && (((e - s) % (md + 1)) == 0);
        ce_e = (((e - s + 1) % (md + 1)) == 0);
        hc_e = n % HT;
        vc_e = n / HT;
        vl_e = vc_e >> mdbl;
        hb   = hc_e >= HBS;
        vb   = vc_e >= (VBS << mdbl);
        hs   = (hc_e >= HSS) && (hc_e < HSE);
        vs   = (vc_e >= (VSS << mdbl)) && (vc_e < (VSE << mdbl));
        de_e = !(hb || vb);
        nl   = nf || (adv && (hc_e == 0));
        chk("ce_pix", int'(a_ce_pix), int'(ce_e));
        chk("hc", int'(a_hc), hc_e);
        chk("vc", int'(a_vc), vc_e);
        chk("vline", int'(a_vline), vl_e);
        chk("hblank", int'(a_hblank), int'(hb));
        chk("vblank", int'(a_vblank), int'(vb));
        chk("hsync", int'(a_hsync), int'(hs));
        chk("vsync", int'(a_vsync), int'(vs));
        chk("de", int'(a_de), int'(de_e));
        chk("new_line", int'(a_new_line), int'(nl));
        chk("new_frame", int'(a_new_frame), int'(nf));
        chk("frame_cnt", int'(a_frame_cnt), mframes);
        chk("hsync_low_pol", int'(b_hsync), int'(!hs));
        chk("vsync_low_pol", int'(b_vsync), int'(!vs));
        chk("b_pos", int'({b_hc, b_vc, b_vline}), (hc_e << 12) | (vc_e << 6) | vl_e);
        chk("b_flags", int'({b_ce_pix, b_hblank, b_vblank, b_de, b_new_line, b_new_frame}),
            int'({ce_e, hb, vb, de_e, nl, nf}));
        chk("b_frame_cnt", int'(b_frame_cnt), mframes);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
        if (!reset_n) begin
            e = 0;
            check_reset();
        end else begin
            check_cycle();
        end
        @(negedge clk_sys);
    endtask

    task automatic wait_frame();
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!a_new_frame && k < 5000);
        if (!a_new_frame) chk("new_frame_timeout", int'(a_new_frame), 1);
    endtask

    task automatic wait_pos(input int h, input int v);
        int k;
        k = 0;
        while (!(int'(a_hc) == h && int'(a_vc) == v) && k < 5000) begin
            tick();
            k++;
        end
        chk("position_timeout", int'(a_hc == HW'(h) && a_vc == VW'(v)), 1);
    endtask

    initial begin
        int period, vmax, vsl, ce_cnt, rst_at;
        vectors = 0; miscompares = 0; e = 0; s = 1; md = 0; mdbl = 0; mframes = 0;
        tbl[0] = '{2'd0, 1'b0, 200,  9,  1};
        tbl[1] = '{2'd1, 1'b0, 400,  9,  1};
        tbl[2] = '{2'd3, 1'b1, 1600, 19, 2};
        tbl[3] = '{2'd2, 1'b1, 1200, 19, 2};
        tbl[4] = '{2'd0, 1'b1, 400,  19, 2};
        tbl[5] = '{2'd3, 1'b0, 800,  9,  1};

        reset_n = 1'b0; ce_div = 2'd0; line_double = 1'b0;
        @(negedge clk_sys);
        check_reset();
        repeat (3) tick();
        reset_n = 1'b1;

        // Mode table: the mode set mid-frame applies from the next frame start.
        for (int i = 0; i < 6; i++) begin
            ce_div = tbl[i].div;
            line_double = tbl[i].dbl;
            wait_frame();
            period = 0; vmax = 0; vsl = 0;
            do begin
                tick();
                period++;
                if (int'(a_vc) > vmax) vmax = int'(a_vc);
                if (a_vsync && a_new_line) vsl++;
            end while (!a_new_frame && period < 5000);
            chk($sformatf("frame_period[%0d]", i), period, tbl[i].exp_period);
            chk($sformatf("vc_max[%0d]", i), vmax, tbl[i].exp_vmax);
            chk($sformatf("vsync_lines[%0d]", i), vsl, tbl[i].exp_vsync_lines);
        end

        // Divider change mid-frame persists until the frame ends.
        ce_div = 2'd3; line_double = 1'b0;
        wait_frame();
        wait_pos(0, 5);
        ce_div = 2'd0;
        ce_cnt = 0;
        repeat (40) begin
            tick();
            if (a_ce_pix) ce_cnt++;
        end
        chk("div4_persists", ce_cnt, 10);
        wait_frame();
        ce_cnt = 0;
        repeat (20) begin
            tick();
            if (a_ce_pix) ce_cnt++;
        end
        chk("div1_after_frame", ce_cnt, 20);

        // Asynchronous reset in the middle of a line.
        wait_pos(10, 5);
        reset_n = 1'b0;
        #1;
        check_reset();
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (5) tick();

        // Randomised mode changes and one random reset pulse.
        rst_at = int'($urandom_range(5000, 15000));
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 63) == 0) ce_div = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) line_double = 1'($urandom_range(0, 1));
            if (i == rst_at) begin
                reset_n = 1'b0;
                #1;
                check_reset();
                tick();
                reset_n = 1'b1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
